matrix_stream_host: RTL

- Host-side memory responder for the matrix multiplier's streaming interface.
- Holds operand matrices A and B, loaded by a host port, and answers the multiplier's ren/raddr read stream with rdata, one element per cycle.
- Captures the multiplier's wen/wdata result stream into a result buffer.
- Issues the start pulse and the sizes value, and reports done, result count and protocol errors back to the host.

---
 rtl/matrix_stream_host_if.sv | 44 ++++
 rtl/matrix_stream_host.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_host_if.sv
// Bundle of the host-side control signals and the multiplier stream signals
// that surround matrix_stream_host. The responder uses the slave modport; the
// host and multiplier side (or a bench standing in for both) uses master.
interface matrix_stream_host_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic [3:0]    cfg_size;
  logic          host_go;
  logic          host_we;
  logic          host_sel;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [AW-1:0] host_res_addr;
  logic [DW-1:0] host_res_data;
  logic          start;
  logic [3:0]    sizes;
  logic          ren;
  logic          raddr;
  logic [DW-1:0] rdata;
  logic          wen;
  logic [DW-1:0] wdata;
  logic          finish;
  logic          busy;
  logic          done;
  logic [AW-1:0] res_count;
  logic          err_rd_over;
  logic          err_wr_over;
  logic          err_size;

  modport slave (
    input  cfg_size, host_go, host_we, host_sel, host_addr, host_wdata,
           host_res_addr, ren, raddr, wen, wdata, finish,
    output host_res_data, start, sizes, rdata, busy, done, res_count,
           err_rd_over, err_wr_over, err_size
  );

  modport master (
    output cfg_size, host_go, host_we, host_sel, host_addr, host_wdata,
           host_res_addr, ren, raddr, wen, wdata, finish,
    input  host_res_data, start, sizes, rdata, busy, done, res_count,
           err_rd_over, err_wr_over, err_size
  );
endinterface

// File: rtl/matrix_stream_host.sv
// Host-side memory responder for the streaming matrix multiplier. Holds the
// A and B operand buffers loaded by the host, serves them element by element
// on the ren/raddr stream, captures the wen/wdata result stream, and runs the
// start/busy/done handshake with sticky error flags for protocol misuse.
module matrix_stream_host #(
  parameter int MAX_SIZE = 6,
  parameter int DW       = 16,
  parameter int DEPTH    = MAX_SIZE * MAX_SIZE,
  parameter int AW       = 6
) (
  input logic               clk,
  input logic               rstn,
  matrix_stream_host_if.slave bus
);

  localparam logic [3:0]  MAX_N   = 4'(MAX_SIZE);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t        r_state;
  logic [3:0]    r_sizes;
  logic          r_start;
  logic          r_busy;
  logic          r_done;
  logic          r_errSize;
  logic          r_errRdOver;
  logic          r_errWrOver;
  logic [AW-1:0] r_ptrA;
  logic [AW-1:0] r_ptrB;
  logic [AW-1:0] r_resCount;
  logic [DW-1:0] r_memA   [DEPTH];
  logic [DW-1:0] r_memB   [DEPTH];
  logic [DW-1:0] r_memRes [DEPTH];

  logic [7:0]    w_nn;
  logic          w_sizeOk;
  logic          w_goOk;
  logic [AW-1:0] w_selPtr;
  logic          w_selAtEnd;
  logic          w_resAtEnd;
  logic [DW-1:0] w_rdata;
  logic [DW-1:0] w_resData;

  // Element count of the latched run; pointers and result count are
  // compared against it, so a zero size (after reset) makes every access an
  // overrun.
  assign w_nn       = {4'd0, r_sizes} * {4'd0, r_sizes};
  assign w_sizeOk   = (bus.cfg_size != 4'd0) && (bus.cfg_size <= MAX_N);
  assign w_goOk     = (r_state == IDLE) && bus.host_go && w_sizeOk;
  assign w_selPtr   = bus.raddr ? r_ptrB : r_ptrA;
  assign w_selAtEnd = ({{(8-AW){1'b0}}, w_selPtr} >= w_nn);
  assign w_resAtEnd = ({{(8-AW){1'b0}}, r_resCount} >= w_nn);

  // Stream data is combinational from the registered pointer so it is valid
  // in the same cycle ren is raised; it reads zero when idle or exhausted.
  always_comb begin
    w_rdata = '0;
    if (bus.ren && !w_selAtEnd) begin
      w_rdata = bus.raddr ? r_memB[w_selPtr] : r_memA[w_selPtr];
    end
  end

  // Host readback of the result buffer; indices beyond the buffer read zero.
  always_comb begin
    w_resData = '0;
    if ({1'b0, bus.host_res_addr} < DEPTH_W) begin
      w_resData = r_memRes[bus.host_res_addr];
    end
  end

  // Run control: latch the size on a legal go, pulse start for one cycle,
  // then hold busy until the multiplier reports finish.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_sizes   <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_errSize <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.host_go) begin
            if (w_sizeOk) begin
              r_sizes   <= bus.cfg_size;
              r_done    <= 1'b0;
              r_errSize <= 1'b0;
              r_start   <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= START;
            end else begin
              r_errSize <= 1'b1;
            end
          end
        end
        START: begin
          r_state <= RUN;
        end
        RUN: begin
          if (bus.finish) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Read pointers advance on every ren in any state and saturate at N*N;
  // a legal go rewinds both streams and clears the overrun flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptrA      <= '0;
      r_ptrB      <= '0;
      r_errRdOver <= 1'b0;
    end else begin
      if (bus.ren) begin
        if (w_selAtEnd) begin
          r_errRdOver <= 1'b1;
        end else if (bus.raddr) begin
          r_ptrB <= r_ptrB + 1'b1;
        end else begin
          r_ptrA <= r_ptrA + 1'b1;
        end
      end
      if (w_goOk) begin
        r_ptrA      <= '0;
        r_ptrB      <= '0;
        r_errRdOver <= 1'b0;
      end
    end
  end

  // Results are appended in arrival order up to N*N; anything beyond is
  // dropped and flagged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resCount  <= '0;
      r_errWrOver <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_memRes[i] <= '0;
    end else begin
      if (bus.wen) begin
        if (w_resAtEnd) begin
          r_errWrOver <= 1'b1;
        end else begin
          r_memRes[r_resCount] <= bus.wdata;
          r_resCount           <= r_resCount + 1'b1;
        end
      end
      if (w_goOk) begin
        r_resCount  <= '0;
        r_errWrOver <= 1'b0;
      end
    end
  end

  // Host loads of A and B are only honoured while idle so operands cannot
  // change under a running multiplication.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_memA[i] <= '0;
        r_memB[i] <= '0;
      end
    end else if ((r_state == IDLE) && bus.host_we &&
                 ({1'b0, bus.host_addr} < DEPTH_W)) begin
      if (bus.host_sel) begin
        r_memB[bus.host_addr] <= bus.host_wdata;
      end else begin
        r_memA[bus.host_addr] <= bus.host_wdata;
      end
    end
  end

  assign bus.host_res_data = w_resData;
  assign bus.start         = r_start;
  assign bus.sizes         = r_sizes;
  assign bus.rdata         = w_rdata;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.res_count     = r_resCount;
  assign bus.err_rd_over   = r_errRdOver;
  assign bus.err_wr_over   = r_errWrOver;
  assign bus.err_size      = r_errSize;

endmodule
